// File: rtl/vu_accum_scheduler_if.sv
// rtl/vu_accum_scheduler_if.sv - audio-side bundle for the VU accumulate scheduler
// Purpose: groups the sample strobes, samples, control and duty outputs of
//          vu_accum_scheduler so they travel as one port.
// Signals: audio_enable, l/r_data_en, l/r_audio_signal, ovr_clr  (to scheduler)
//          l/r_duty, l/r_duty_valid, overrun, busy             (from scheduler)
// Modports: master = audio data path / test driver, slave = scheduler.
interface vu_accum_scheduler_if #(
    parameter int SAMPLE_W = 8,
    parameter int DUTY_W   = 7
);
    logic                audio_enable;
    logic                l_data_en;
    logic                r_data_en;
    logic [SAMPLE_W-1:0] l_audio_signal;
    logic [SAMPLE_W-1:0] r_audio_signal;
    logic                ovr_clr;
    logic [DUTY_W-1:0]   l_duty;
    logic [DUTY_W-1:0]   r_duty;
    logic                l_duty_valid;
    logic                r_duty_valid;
    logic [1:0]          overrun;
    logic                busy;

    modport master (
        output audio_enable, l_data_en, r_data_en, l_audio_signal, r_audio_signal, ovr_clr,
        input  l_duty, r_duty, l_duty_valid, r_duty_valid, overrun, busy
    );

    modport slave (
        input  audio_enable, l_data_en, r_data_en, l_audio_signal, r_audio_signal, ovr_clr,
        output l_duty, r_duty, l_duty_valid, r_duty_valid, overrun, busy
    );
endinterface

// File: rtl/vu_accum_scheduler.sv
// rtl/vu_accum_scheduler.sv - shared-adder L/R VU averaging, ballistics and duty output
// Purpose: captures left/right sample strobes, time-multiplexes one adder over
//          a NUM_AVG-sample window per channel, applies fall-back decay and
//          emits a held duty value with a one-cycle valid pulse per channel.
// Ports:   clk    - system clock
//          reset  - synchronous, active-high reset
//          bus    - vu_accum_scheduler_if.slave (strobes, samples, ovr_clr in;
//                   duties, valid pulses, overrun, busy out)
module vu_accum_scheduler #(
    parameter int NUM_AVG    = 16,
    parameter int SAMPLE_W   = 8,
    parameter int DUTY_W     = 7,
    parameter int DECAY_STEP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vu_accum_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(NUM_AVG);
    localparam int SUM_W = SAMPLE_W + CNT_W;

    typedef enum logic [2:0] {IDLE, ACC_L, ACC_R, DUMP_L, DUMP_R} state_t;

    state_t              state_q, state_d;
    logic                pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [SAMPLE_W-1:0] smp_l_q, smp_l_d, smp_r_q, smp_r_d;
    logic [SUM_W-1:0]    sum_l_q, sum_l_d, sum_r_q, sum_r_d;
    logic [CNT_W-1:0]    cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
    logic [DUTY_W-1:0]   duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic                vld_l_q, vld_l_d, vld_r_q, vld_r_d;
    logic [1:0]          ovr_q, ovr_d;

    logic                stb_l, stb_r, grant_l, grant_r;
    logic [DUTY_W-1:0]   new_l, new_r;

    // Top DUTY_W bits of the window sum equal the top bits of the average.
    assign new_l = sum_l_q[SUM_W-1 -: DUTY_W];
    assign new_r = sum_r_q[SUM_W-1 -: DUTY_W];

    function automatic logic [DUTY_W-1:0] fall_back(input logic [DUTY_W-1:0] nv,
                                                    input logic [DUTY_W-1:0] held);
        logic [DUTY_W-1:0] dec;
        if (nv >= held) return nv;
        dec = (held > DUTY_W'(DECAY_STEP)) ? held - DUTY_W'(DECAY_STEP) : '0;
        return (nv > dec) ? nv : dec;
    endfunction

    assign stb_l   = bus.audio_enable && bus.l_data_en;
    assign stb_r   = bus.audio_enable && bus.r_data_en;
    assign grant_l = (state_q == IDLE) && pend_l_q;
    assign grant_r = (state_q == IDLE) && !pend_l_q && pend_r_q;

    always_comb begin
        state_d  = state_q;
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        smp_l_d  = smp_l_q;
        smp_r_d  = smp_r_q;
        sum_l_d  = sum_l_q;
        sum_r_d  = sum_r_q;
        cnt_l_d  = cnt_l_q;
        cnt_r_d  = cnt_r_q;
        duty_l_d = duty_l_q;
        duty_r_d = duty_r_q;
        vld_l_d  = 1'b0;
        vld_r_d  = 1'b0;
        ovr_d    = ovr_q;

        case (state_q)
            IDLE: begin
                if (pend_l_q)      state_d = ACC_L;
                else if (pend_r_q) state_d = ACC_R;
            end
            ACC_L: begin
                sum_l_d = sum_l_q + SUM_W'(smp_l_q);
                cnt_l_d = cnt_l_q + 1'b1;
                state_d = (cnt_l_q == CNT_W'(NUM_AVG - 1)) ? DUMP_L : IDLE;
            end
            ACC_R: begin
                sum_r_d = sum_r_q + SUM_W'(smp_r_q);
                cnt_r_d = cnt_r_q + 1'b1;
                state_d = (cnt_r_q == CNT_W'(NUM_AVG - 1)) ? DUMP_R : IDLE;
            end
            DUMP_L: begin
                duty_l_d = fall_back(new_l, duty_l_q);
                vld_l_d  = 1'b1;
                sum_l_d  = '0;
                cnt_l_d  = '0;
                state_d  = IDLE;
            end
            DUMP_R: begin
                duty_r_d = fall_back(new_r, duty_r_q);
                vld_r_d  = 1'b1;
                sum_r_d  = '0;
                cnt_r_d  = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe landing on the grant cycle overwrites the granted sample;
        // the grant still clears pend so that sample is accumulated once only.
        if (ovr_clr_seen()) ovr_d = 2'b00;
        if (stb_l) begin
            smp_l_d = {~bus.l_audio_signal[SAMPLE_W-1], bus.l_audio_signal[SAMPLE_W-2:0]};
            if (pend_l_q) ovr_d[0] = 1'b1;
        end
        if (stb_r) begin
            smp_r_d = {~bus.r_audio_signal[SAMPLE_W-1], bus.r_audio_signal[SAMPLE_W-2:0]};
            if (pend_r_q) ovr_d[1] = 1'b1;
        end
        pend_l_d = grant_l ? 1'b0 : (stb_l ? 1'b1 : pend_l_q);
        pend_r_d = grant_r ? 1'b0 : (stb_r ? 1'b1 : pend_r_q);

        // Music stopped: flush the datapath but keep the overrun history.
        if (!bus.audio_enable) begin
            state_d  = IDLE;
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
            sum_l_d  = '0;
            sum_r_d  = '0;
            cnt_l_d  = '0;
            cnt_r_d  = '0;
            duty_l_d = '0;
            duty_r_d = '0;
            vld_l_d  = 1'b0;
            vld_r_d  = 1'b0;
        end
    end

    function automatic logic ovr_clr_seen();
        return bus.ovr_clr;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            smp_l_q  <= '0;
            smp_r_q  <= '0;
            sum_l_q  <= '0;
            sum_r_q  <= '0;
            cnt_l_q  <= '0;
            cnt_r_q  <= '0;
            duty_l_q <= '0;
            duty_r_q <= '0;
            vld_l_q  <= 1'b0;
            vld_r_q  <= 1'b0;
            ovr_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            smp_l_q  <= smp_l_d;
            smp_r_q  <= smp_r_d;
            sum_l_q  <= sum_l_d;
            sum_r_q  <= sum_r_d;
            cnt_l_q  <= cnt_l_d;
            cnt_r_q  <= cnt_r_d;
            duty_l_q <= duty_l_d;
            duty_r_q <= duty_r_d;
            vld_l_q  <= vld_l_d;
            vld_r_q  <= vld_r_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.l_duty       = duty_l_q;
    assign bus.r_duty       = duty_r_q;
    assign bus.l_duty_valid = vld_l_q;
    assign bus.r_duty_valid = vld_r_q;
    assign bus.overrun      = ovr_q;
    assign bus.busy         = (state_q != IDLE) || pend_l_q || pend_r_q;
endmodule

// File: tb/tb_vu_accum_scheduler.sv
// tb/tb_vu_accum_scheduler.sv - directed self-checking bench for vu_accum_scheduler
module tb_vu_accum_scheduler;
    localparam int NUM_AVG    = 16;
    localparam int SAMPLE_W   = 8;
    localparam int DUTY_W     = 7;
    localparam int DECAY_STEP = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   lv_cnt = 0;
    int   rv_cnt = 0;

    vu_accum_scheduler_if #(.SAMPLE_W(SAMPLE_W), .DUTY_W(DUTY_W)) bus ();

    vu_accum_scheduler #(
        .NUM_AVG(NUM_AVG), .SAMPLE_W(SAMPLE_W), .DUTY_W(DUTY_W), .DECAY_STEP(DECAY_STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.l_duty_valid === 1'b1) lv_cnt <= lv_cnt + 1;
        if (bus.r_duty_valid === 1'b1) rv_cnt <= rv_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.audio_enable   = 1'b1;
        bus.l_data_en      = 1'b0;
        bus.r_data_en      = 1'b0;
        bus.l_audio_signal = '0;
        bus.r_audio_signal = '0;
        bus.ovr_clr        = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Strobe held for exactly one cycle; returns one cycle after the strobe cycle.
    task automatic strobe(input logic dl, input logic dr, input logic [7:0] lv, input logic [7:0] rv);
        bus.l_data_en      = dl;
        bus.r_data_en      = dr;
        bus.l_audio_signal = lv;
        bus.r_audio_signal = rv;
        tick();
        bus.l_data_en = 1'b0;
        bus.r_data_en = 1'b0;
    endtask

    task automatic send_n(input int n, input logic dl, input logic dr, input logic [7:0] lv, input logic [7:0] rv);
        for (int i = 0; i < n; i++) begin
            strobe(dl, dr, lv, rv);
            repeat (7) tick();
        end
    endtask

    task automatic test_reset();
        bus.audio_enable = 1'b1;
        bus.l_data_en = 1'b0; bus.r_data_en = 1'b0;
        bus.l_audio_signal = '0; bus.r_audio_signal = '0; bus.ovr_clr = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.l_duty !== 7'd0) begin bad++; $display("FAIL reset_l_duty: got %0d expected 0", bus.l_duty); end
        total++; if (bus.r_duty !== 7'd0) begin bad++; $display("FAIL reset_r_duty: got %0d expected 0", bus.r_duty); end
        total++; if ({bus.l_duty_valid, bus.r_duty_valid} !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b expected 00", {bus.l_duty_valid, bus.r_duty_valid}); end
        total++; if (bus.overrun !== 2'b00) begin bad++; $display("FAIL reset_overrun: got %b expected 00", bus.overrun); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
    endtask

    task automatic test_const_left();
        int l0, r0;
        do_reset();
        l0 = lv_cnt; r0 = rv_cnt;
        send_n(15, 1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (lv_cnt !== l0) begin bad++; $display("FAIL const_early_valid: got %0d pulses expected 0", lv_cnt - l0); end
        strobe(1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL const_busy_t1: got %b expected 1", bus.busy); end
        tick(); tick();
        total++; if (bus.l_duty_valid !== 1'b0) begin bad++; $display("FAIL const_valid_t3: got %b expected 0", bus.l_duty_valid); end
        tick();
        total++; if (bus.l_duty_valid !== 1'b1) begin bad++; $display("FAIL const_valid_t4: got %b expected 1", bus.l_duty_valid); end
        total++; if (bus.l_duty !== 7'h7F) begin bad++; $display("FAIL const_l_duty: got %0h expected 7f", bus.l_duty); end
        tick();
        total++; if (bus.l_duty_valid !== 1'b0) begin bad++; $display("FAIL const_valid_t5: got %b expected 0", bus.l_duty_valid); end
        repeat (4) tick();
        total++; if (lv_cnt !== l0 + 1) begin bad++; $display("FAIL const_l_pulses: got %0d expected 1", lv_cnt - l0); end
        total++; if (rv_cnt !== r0) begin bad++; $display("FAIL const_r_pulses: got %0d expected 0", rv_cnt - r0); end
    endtask

    task automatic test_simultaneous();
        int l0, r0;
        do_reset();
        l0 = lv_cnt; r0 = rv_cnt;
        send_n(16, 1'b1, 1'b1, 8'h00, 8'h80);
        total++; if (bus.l_duty !== 7'd64) begin bad++; $display("FAIL sim_l_duty: got %0d expected 64", bus.l_duty); end
        total++; if (bus.r_duty !== 7'd0) begin bad++; $display("FAIL sim_r_duty: got %0d expected 0", bus.r_duty); end
        total++; if (bus.overrun !== 2'b00) begin bad++; $display("FAIL sim_overrun: got %b expected 00", bus.overrun); end
        total++; if (lv_cnt !== l0 + 1 || rv_cnt !== r0 + 1) begin bad++; $display("FAIL sim_pulses: got l=%0d r=%0d expected l=1 r=1", lv_cnt - l0, rv_cnt - r0); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sim_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_decay();
        do_reset();
        send_n(16, 1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (bus.l_duty !== 7'd127) begin bad++; $display("FAIL decay_start: got %0d expected 127", bus.l_duty); end
        send_n(16, 1'b1, 1'b0, 8'h00, 8'h00);
        total++; if (bus.l_duty !== 7'd123) begin bad++; $display("FAIL decay_step1: got %0d expected 123", bus.l_duty); end
        for (int w = 0; w < 14; w++) send_n(16, 1'b1, 1'b0, 8'h00, 8'h00);
        total++; if (bus.l_duty !== 7'd67) begin bad++; $display("FAIL decay_step15: got %0d expected 67", bus.l_duty); end
        send_n(16, 1'b1, 1'b0, 8'h00, 8'h00);
        total++; if (bus.l_duty !== 7'd64) begin bad++; $display("FAIL decay_floor: got %0d expected 64", bus.l_duty); end
        send_n(16, 1'b1, 1'b0, 8'h00, 8'h00);
        total++; if (bus.l_duty !== 7'd64) begin bad++; $display("FAIL decay_hold: got %0d expected 64", bus.l_duty); end
    endtask

    task automatic test_overrun();
        int l0;
        do_reset();
        strobe(1'b1, 1'b0, 8'h7F, 8'h00);
        strobe(1'b1, 1'b0, 8'h80, 8'h00);
        total++; if (bus.overrun !== 2'b01) begin bad++; $display("FAIL ovr_set: got %b expected 01", bus.overrun); end
        repeat (7) tick();
        l0 = lv_cnt;
        send_n(14, 1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (lv_cnt !== l0) begin bad++; $display("FAIL ovr_count_early: got %0d pulses expected 0", lv_cnt - l0); end
        send_n(1, 1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (lv_cnt !== l0 + 1) begin bad++; $display("FAIL ovr_count_window: got %0d pulses expected 1", lv_cnt - l0); end
        total++; if (bus.l_duty !== 7'd119) begin bad++; $display("FAIL ovr_l_duty: got %0d expected 119", bus.l_duty); end
        total++; if (bus.overrun !== 2'b01) begin bad++; $display("FAIL ovr_sticky: got %b expected 01", bus.overrun); end
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        total++; if (bus.overrun !== 2'b00) begin bad++; $display("FAIL ovr_clear: got %b expected 00", bus.overrun); end
    endtask

    task automatic test_audio_enable();
        int l0;
        do_reset();
        send_n(16, 1'b1, 1'b0, 8'h7F, 8'h00);
        send_n(10, 1'b1, 1'b0, 8'h7F, 8'h00);
        l0 = lv_cnt;
        bus.audio_enable = 1'b0;
        tick();
        total++; if (bus.l_duty !== 7'd0) begin bad++; $display("FAIL ae_l_duty: got %0d expected 0", bus.l_duty); end
        total++; if (bus.l_duty_valid !== 1'b0) begin bad++; $display("FAIL ae_valid: got %b expected 0", bus.l_duty_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ae_busy: got %b expected 0", bus.busy); end
        bus.audio_enable = 1'b1;
        tick();
        send_n(15, 1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (lv_cnt !== l0 || bus.l_duty !== 7'd0) begin bad++; $display("FAIL ae_partial: got pulses=%0d duty=%0d expected pulses=0 duty=0", lv_cnt - l0, bus.l_duty); end
        send_n(1, 1'b1, 1'b0, 8'h7F, 8'h00);
        total++; if (lv_cnt !== l0 + 1 || bus.l_duty !== 7'd127) begin bad++; $display("FAIL ae_full: got pulses=%0d duty=%0d expected pulses=1 duty=127", lv_cnt - l0, bus.l_duty); end
    endtask

    task automatic test_reset_in_acc();
        do_reset();
        send_n(16, 1'b0, 1'b1, 8'h00, 8'h7F);
        strobe(1'b0, 1'b1, 8'h00, 8'h7F);
        strobe(1'b0, 1'b1, 8'h00, 8'h7F);
        total++; if (bus.busy !== 1'b1 || bus.overrun !== 2'b10 || bus.r_duty !== 7'd127) begin
            bad++; $display("FAIL racc_pre: got busy=%b ovr=%b r_duty=%0d expected busy=1 ovr=10 r_duty=127", bus.busy, bus.overrun, bus.r_duty);
        end
        reset = 1'b1;
        tick();
        total++; if (bus.l_duty !== 7'd0 || bus.r_duty !== 7'd0) begin bad++; $display("FAIL racc_duty: got l=%0d r=%0d expected 0 0", bus.l_duty, bus.r_duty); end
        total++; if ({bus.l_duty_valid, bus.r_duty_valid} !== 2'b00) begin bad++; $display("FAIL racc_valid: got %b expected 00", {bus.l_duty_valid, bus.r_duty_valid}); end
        total++; if (bus.overrun !== 2'b00) begin bad++; $display("FAIL racc_overrun: got %b expected 00", bus.overrun); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL racc_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_const_left();
        test_simultaneous();
        test_decay();
        test_overrun();
        test_audio_enable();
        test_reset_in_acc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vu_accum_scheduler.md
Name: vu_accum_scheduler

Overview:
- Time-multiplexes one shared unsigned adder between the left and right VU channels.
- Arbitrates the two 96 kHz sample strobes and sequences a NUM_AVG-sample averaging window per channel.
- Applies fall-back (decay) ballistics and emits a per-channel PWM duty value with a one-cycle valid strobe.
- Sits between the I2S/audio data path and the VU PWM generators; replaces the per-channel accumulator IP.

Parameters:
- NUM_AVG, 16: samples per averaging window; power of two, 2..256.
- SAMPLE_W, 8: width of the signed audio input (MSBs of audio word).
- DUTY_W, 7: width of the duty output; must be <= SAMPLE_W.
- DECAY_STEP, 4: maximum drop of the held duty per window, in duty LSBs.

Ports:
- clk  in  1  system clock (49.152 MHz)
- reset  in  1  synchronous, active-high reset
- audio_enable  in  1  1 = music playing; 0 = synchronous clear of datapath
- l_data_en  in  1  left sample strobe, one clk wide
- r_data_en  in  1  right sample strobe, one clk wide
- l_audio_signal  in  SAMPLE_W  left sample, two's complement
- r_audio_signal  in  SAMPLE_W  right sample, two's complement
- ovr_clr  in  1  clears both overrun flags
- l_duty  out  DUTY_W  left held duty cycle
- r_duty  out  DUTY_W  right held duty cycle
- l_duty_valid  out  1  one-cycle pulse when l_duty is updated
- r_duty_valid  out  1  one-cycle pulse when r_duty is updated
- overrun  out  2  sticky flags, [1] = right, [0] = left
- busy  out  1  high when the FSM is not in IDLE or any pending flag is set

Behaviour:
- Reset: all outputs 0, sums 0, counts 0, pending flags 0, state IDLE.

Capture:
- On x_data_en && audio_enable, latch the sample as unsigned ({~msb, rest}) and set pend_x.
- If pend_x is already set when a new strobe arrives: set overrun[x] (sticky); the new sample overwrites the old one; pend_x stays 1.
- ovr_clr clears overrun in the same cycle it is seen. A simultaneous overrun event wins, so the flag stays 1.

FSM states:
- IDLE:
  - If pend_l, go to ACC_L and clear pend_l.
  - Else if pend_r, go to ACC_R and clear pend_r.
  - Left has fixed priority. If both are pending, right is serviced on the next IDLE visit.
- ACC_x:
  - sum_x <= sum_x + sample_x, using width SAMPLE_W + log2(NUM_AVG). This cannot overflow.
  - cnt_x++.
  - If cnt_x was NUM_AVG-1, go to DUMP_x; else go to IDLE.
- DUMP_x:
  - avg = sum_x >> log2(NUM_AVG); new = avg[SAMPLE_W-1 -: DUTY_W].
  - If new >= duty_x, duty_x <= new.
  - Else duty_x <= max(new, duty_x - DECAY_STEP), saturating at 0.
  - x_duty_valid <= 1 for exactly one cycle.
  - sum_x <= 0, cnt_x <= 0, go to IDLE.

Latency (isolated left strobe at cycle t):
- pend set at end of t; IDLE grant at t+1; ACC_L at t+2; DUMP_L at t+3.
- l_duty and l_duty_valid are visible at t+4.
- Non-final sample: service complete, back in IDLE at t+3.

Other rules:
- A strobe arriving during any state is captured; capture is independent of the FSM.
- audio_enable = 0: same cycle, clear sums, counts, pending flags and duties; state goes to IDLE; valid pulses are suppressed. Overrun flags are kept.
- reset has priority over audio_enable and ovr_clr.
- Worst-case service time is 3 clk per channel, i.e. 6 clk for both. Strobes closer than that on the same channel overrun.

Test Plan:
- Constant left input 8'h7F (unsigned 255) for 16 strobes, 512 clk apart -> after the 16th strobe at t, l_duty = 7'h7F and l_duty_valid pulses once at t+4; r_duty_valid never asserts.
- Simultaneous l/r strobes, left 8'h00 (unsigned 128), right 8'h80 (unsigned 0), repeated 16× -> ACC_L precedes ACC_R by 2 clk every time; l_duty = 64 and r_duty = 0; no overrun.
- Window of 255 (duty 127), then a window of 128 (new 64), DECAY_STEP = 4 -> l_duty steps 127 → 123; after 16 further windows at 128, l_duty = 64 and stays there.
- Two left strobes 1 clk apart -> overrun = 2'b01; only the second sample is accumulated (cnt advances by 1); ovr_clr pulse -> overrun = 0 next cycle.
- audio_enable dropped after 10 left samples, then re-raised -> duties = 0 with no valid pulse; the next window needs a full 16 fresh samples.
- reset asserted while in ACC_R -> next cycle state is IDLE; all outputs, overrun and busy are 0.
